// File: rtl/inst_encoder_loader.sv
`default_nettype none
// inst_encoder_loader: packs decoded RV32I fields into 32-bit instruction words
// and streams them into instruction memory through a req/ack write port.
module inst_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [CNT_W-1:0]  NumWords,
  input  logic              InValid,
  output logic              InReady,
  input  logic [6:0]        Op,
  input  logic [2:0]        Fn3,
  input  logic [6:0]        Fn7,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [31:0]       Imm,
  input  logic [2:0]        ImmType,
  output logic [3:0]        ImemWE,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [31:0]       ImemWData,
  input  logic              ImemAck,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  WordCnt,
  output logic [7:0]        ErrCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;

  logic [31:0]       enc_word;
  logic              imm_ok;
  logic              in_ready;
  logic              accept;
  logic              write_done;
  logic [CNT_W:0]    committed;
  logic              unused_addr_lsb;

  // The low address bits are forced to zero, so they never reach the datapath.
  assign unused_addr_lsb = ^BaseAddr[1:0];

  always_comb begin
    enc_word = '0;
    imm_ok   = 1'b0;
    case (ImmType)
      IMM_R: begin
        enc_word = {Fn7, Rs2, Rs1, Fn3, Rd, Op};
        imm_ok   = 1'b1;
      end
      IMM_I: begin
        enc_word = {Imm[11:0], Rs1, Fn3, Rd, Op};
        imm_ok   = (Imm[31:11] == {21{Imm[11]}});
      end
      IMM_S: begin
        enc_word = {Imm[11:5], Rs2, Rs1, Fn3, Imm[4:0], Op};
        imm_ok   = (Imm[31:11] == {21{Imm[11]}});
      end
      IMM_B: begin
        enc_word = {Imm[12], Imm[10:5], Rs2, Rs1, Fn3, Imm[4:1], Imm[11], Op};
        imm_ok   = (Imm[31:12] == {20{Imm[12]}}) && !Imm[0];
      end
      IMM_U: begin
        enc_word = {Imm[31:12], Rd, Op};
        imm_ok   = (Imm[11:0] == 12'd0);
      end
      IMM_J: begin
        enc_word = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Op};
        imm_ok   = (Imm[31:20] == {12{Imm[20]}}) && !Imm[0];
      end
      default: begin
        enc_word = '0;
        imm_ok   = 1'b0;
      end
    endcase
  end

  // A word sitting in the output register counts as committed even if it is
  // being acked now: that ack bumps WordCnt by the same amount.
  assign committed  = {1'b0, word_cnt_q} + {{CNT_W{1'b0}}, we_q};
  assign in_ready   = (state_q == ST_LOAD) && !Abort && (!we_q || ImemAck)
                      && (committed < {1'b0, num_q});
  assign accept     = InValid && in_ready;
  assign write_done = we_q && ImemAck;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    num_d      = num_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start && !Abort) begin
          addr_d     = {BaseAddr[ADDR_W-1:2], 2'b00};
          num_d      = NumWords;
          word_cnt_d = '0;
          err_cnt_d  = '0;
          if (NumWords == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
            done_d  = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        if (Abort) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
        end else begin
          if (write_done) begin
            addr_d     = addr_q + ADDR_W'(4);
            word_cnt_d = word_cnt_q + CNT_W'(1);
            we_d       = 1'b0;
            if (word_cnt_q + CNT_W'(1) == num_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
          if (accept) begin
            if (imm_ok) begin
              we_d    = 1'b1;
              wdata_d = enc_word;
            end else if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      num_q      <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign InReady   = in_ready;
  assign ImemWE    = {4{we_q}};
  assign ImemAddr  = addr_q;
  assign ImemWData = wdata_q;
  assign Busy      = (state_q == ST_LOAD);
  assign Done      = done_q;
  assign WordCnt   = word_cnt_q;
  assign ErrCnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Reverse of the pipeline's instruction decoder: takes decoded RISC-V instruction fields (Op, Fn3, Fn7, register indices, immediate, ImmType) and packs them into 32-bit RV32I instruction words.
- Writes the words sequentially into the instruction BRAM through a req/ack write port.
- Serves as the boot/debug program loader ahead of the CPU core; also used as a decoder-consistency generator in verification.

Parameters:
- ADDR_W, 32, width of the instruction memory byte address; addresses wrap modulo 2^ADDR_W.
- CNT_W, 16, width of the word-count registers.

Ports:
- CPU_CLK  in  1  single clock, rising edge.
- CPU_RST_N  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse that begins a load session.
- Abort  in  1  synchronous session cancel.
- BaseAddr  in  ADDR_W  first write byte address; bits [1:0] forced to 0.
- NumWords  in  CNT_W  number of valid words to write.
- InValid  in  1  field tuple valid.
- InReady  out  1  encoder can accept a tuple.
- Op  in  7  opcode.
- Fn3  in  3  funct3.
- Fn7  in  7  funct7.
- Rd  in  5  destination register.
- Rs1  in  5  source register 1.
- Rs2  in  5  source register 2.
- Imm  in  32  immediate as a signed value, before format packing.
- ImmType  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; values 6 and 7 are illegal.
- ImemWE  out  4  byte write enables, 4'b1111 during a word write, else 0.
- ImemAddr  out  ADDR_W  write byte address.
- ImemWData  out  32  encoded instruction word.
- ImemAck  in  1  memory accepted the write this cycle.
- Busy  out  1  session active.
- Done  out  1  session complete; sticky until the next Start.
- WordCnt  out  CNT_W  words written in this session.
- ErrCnt  out  8  tuples rejected, saturating.

Behaviour:
- Reset (async, CPU_RST_N=0):
  - State IDLE.
  - All outputs 0: InReady, ImemWE, ImemAddr, ImemWData, Busy, Done, WordCnt, ErrCnt.
  - Any pending write is dropped.
- States: IDLE, LOAD, DONE.
- IDLE or DONE, on Start:
  - Latch BaseAddr and NumWords; clear WordCnt, ErrCnt and Done.
  - If NumWords==0, go to DONE next cycle (Done=1). Otherwise go to LOAD (Busy=1).
  - Start is ignored while in LOAD.
- LOAD, accepting tuples:
  - InReady=1 when the output register is empty, or holds a write that is acked this cycle, and WordCnt plus pending words < NumWords.
  - A tuple is accepted when InValid and InReady are both 1.
- LOAD, encoding:
  - Encoding is combinational and registered on acceptance.
  - ImemWE, ImemAddr and ImemWData are asserted in the cycle after acceptance.
  - They are held stable until ImemAck=1.
  - Sustained throughput is 1 word per cycle while ImemAck=1.
- LOAD, on ImemAck:
  - ImemAddr advances by 4 (with wrap) and WordCnt increments.
  - If the output register was not refilled, ImemWE drops to 0 next cycle.
  - When WordCnt reaches NumWords: go to DONE, Busy=0, Done=1, InReady=0.
- Encoding (bit fields, MSB first):
  - R: Fn7 | Rs2 | Rs1 | Fn3 | Rd | Op.
  - I: Imm[11:0] | Rs1 | Fn3 | Rd | Op.
  - S: Imm[11:5] | Rs2 | Rs1 | Fn3 | Imm[4:0] | Op.
  - B: Imm[12] | Imm[10:5] | Rs2 | Rs1 | Fn3 | Imm[4:1] | Imm[11] | Op.
  - U: Imm[31:12] | Rd | Op.
  - J: Imm[20] | Imm[10:1] | Imm[11] | Imm[19:12] | Rd | Op.
  - Fn7 is used only for R; unused fields are ignored.
- Range check (tuple is rejected on violation):
  - I and S: Imm must equal the sign-extension of Imm[11:0].
  - B: Imm must fit 13-bit signed and Imm[0]==0.
  - J: Imm must fit 21-bit signed and Imm[0]==0.
  - U: Imm[11:0]==0.
  - ImmType 6 or 7 is always rejected.
- Rejected tuple:
  - It is still handshaken (consumed).
  - It produces no write, does not advance the address, and does not count toward NumWords.
  - ErrCnt increments, saturating at 255.
- Abort in LOAD:
  - Next cycle: state IDLE, ImemWE=0, pending word discarded.
  - WordCnt and ErrCnt are kept; Done stays 0.
- Simultaneous Start and Abort: Abort wins.
- Address wrap: BaseAddr = 2^ADDR_W - 4 is followed by address 0.

Test Plan:
- Start BaseAddr=0x100, NumWords=1; I-type Op=0010011, Fn3=0, Rd=1, Rs1=0, Imm=5 -> cycle after accept: ImemWE=4'hF, ImemAddr=0x100, ImemWData=0x00500093; ack -> Done=1, WordCnt=1.
- B-type Op=1100011, Fn3=0, Rs1=1, Rs2=2, Imm=-8 -> 0xFE208CE3. J-type Op=1101111, Rd=1, Imm=0x800 -> 0x001000EF. U-type Op=0110111, Rd=5, Imm=0x12345000 -> 0x123452B7. Sent back-to-back with ImemAck=1 -> consecutive addresses +4, one word per cycle.
- I-type Imm=2048, then a B-type with Imm=3 -> both consumed, no ImemWE, ErrCnt=2, WordCnt unchanged.
- ImemAck held low for 3 cycles mid-stream -> ImemWE, ImemAddr and ImemWData stable, InReady=0; released -> stream resumes with no loss or duplication.
- Start with NumWords=0 -> Done=1 next cycle, no writes. Abort during LOAD with a pending write -> IDLE, ImemWE=0 next cycle.
- Assert CPU_RST_N=0 mid-write (asynchronously) -> all outputs 0 immediately. BaseAddr=0xFFFFFFFC, NumWords=2 -> writes at 0xFFFFFFFC then 0x0.
